// File: rtl/axis_frame_source_pkg.sv
// Shared types and defaults for the axis_frame_source stream transmitter.
// The optional checksum beat is enabled by AXIS_FRAME_SOURCE_CHECKSUM_EN.
package axis_frame_source_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 32;
  localparam int unsigned DEPTH_DEFAULT      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2,
    FIN  = 2'd3
  } state_e;

  // Fill count and frame length must be able to hold the value DEPTH itself.
  function automatic int unsigned len_w_f(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_frame_buffer.sv
// Word buffer for axis_frame_source: synchronous write, asynchronous read,
// wrap-around write pointer and a fill count that saturates at DEPTH.
module axis_frame_buffer
  import axis_frame_source_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned DEPTH      = DEPTH_DEFAULT,
  parameter int unsigned LEN_W      = len_w_f(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [DATA_WIDTH-1:0]    wr_data_i,
  input  logic                     clr_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]    rd_data_c_o,
  output logic [LEN_W-1:0]         count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      wr_ptr_d;
  logic [LEN_W-1:0]      count_q;
  logic [LEN_W-1:0]      count_d;
  logic                  wr_fire_c;

  assign wr_fire_c = wr_en_i && !clr_i && !rst_i;

  // Pointer wraps naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (count_q != LEN_W'(DEPTH)) begin
        count_d = count_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (wr_fire_c) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_c_o = mem_q[rd_addr_i];
  assign count_o     = count_q;

endmodule

// File: rtl/axis_frame_source.sv
// AXI-Stream frame transmitter: preload words, pulse START, stream FRAME_LEN beats.
// Define AXIS_FRAME_SOURCE_CHECKSUM_EN to append an XOR checksum beat carrying TLAST.
module axis_frame_source
  import axis_frame_source_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned DEPTH      = DEPTH_DEFAULT,
  parameter int unsigned LEN_W      = len_w_f(DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  START,
  input  logic [LEN_W-1:0]      FRAME_LEN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic                  M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  state_e                state_q;
  state_e                state_d;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      len_d;
  logic [LEN_W-1:0]      beat_q;
  logic [LEN_W-1:0]      beat_d;
  logic                  tvalid_q;
  logic                  tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [DATA_WIDTH-1:0] tdata_d;
  logic                  tlast_q;
  logic                  tlast_d;
  logic                  busy_q;
  logic                  busy_d;
  logic                  done_q;
  logic                  done_d;
  logic                  err_q;
  logic                  err_d;
`ifdef AXIS_FRAME_SOURCE_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;
  logic [DATA_WIDTH-1:0] csum_d;
`endif

  logic                  wr_en_c;
  logic                  clr_c;
  logic [PTR_W-1:0]      rd_addr_c;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic [LEN_W-1:0]      fill_count;
  logic                  start_ok_c;
  logic                  hs_c;
  logic                  last_beat_c;
  logic                  next_last_c;

  axis_frame_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .LEN_W      (LEN_W)
  ) u_buffer (
    .clk_i       (ACLK),
    .rst_i       (ARESET),
    .wr_en_i     (wr_en_c),
    .wr_data_i   (WR_DATA),
    .clr_i       (clr_c),
    .rd_addr_i   (rd_addr_c),
    .rd_data_c_o (rd_data_c),
    .count_o     (fill_count)
  );

  assign start_ok_c  = (FRAME_LEN != '0) && (FRAME_LEN <= fill_count);
  assign hs_c        = tvalid_q && M_AXIS_TREADY;
  assign last_beat_c = (beat_q == (len_q - LEN_W'(1)));
  assign next_last_c = ((beat_q + LEN_W'(2)) == len_q);

  // While sending, the RAM is addressed one word ahead so the next beat is ready.
  assign rd_addr_c = (state_q == SEND) ? PTR_W'(beat_q + LEN_W'(1)) : '0;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    beat_d   = beat_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    wr_en_c  = 1'b0;
    clr_c    = 1'b0;
`ifdef AXIS_FRAME_SOURCE_CHECKSUM_EN
    csum_d   = csum_q;
`endif

    case (state_q)
      IDLE: begin
        if (START) begin
          if (start_ok_c) begin
            len_d    = FRAME_LEN;
            beat_d   = '0;
            tdata_d  = rd_data_c;
            tvalid_d = 1'b1;
            busy_d   = 1'b1;
`ifdef AXIS_FRAME_SOURCE_CHECKSUM_EN
            tlast_d  = 1'b0;
            csum_d   = '0;
`else
            tlast_d  = (FRAME_LEN == LEN_W'(1));
`endif
            state_d  = SEND;
          end else begin
            err_d = 1'b1;
          end
        end else if (WR_EN) begin
          wr_en_c = 1'b1;
        end
      end

      SEND: begin
        if (hs_c) begin
`ifdef AXIS_FRAME_SOURCE_CHECKSUM_EN
          csum_d = csum_q ^ tdata_q;
`endif
          if (last_beat_c) begin
`ifdef AXIS_FRAME_SOURCE_CHECKSUM_EN
            tdata_d = csum_q ^ tdata_q;
            tlast_d = 1'b1;
            state_d = CSUM;
`else
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = FIN;
`endif
          end else begin
            beat_d  = beat_q + LEN_W'(1);
            tdata_d = rd_data_c;
`ifdef AXIS_FRAME_SOURCE_CHECKSUM_EN
            tlast_d = 1'b0;
`else
            tlast_d = next_last_c;
`endif
          end
        end
      end

`ifdef AXIS_FRAME_SOURCE_CHECKSUM_EN
      CSUM: begin
        if (hs_c) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = FIN;
        end
      end
`endif

      FIN: begin
        clr_c   = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= IDLE;
      len_q    <= '0;
      beat_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef AXIS_FRAME_SOURCE_CHECKSUM_EN
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign ERR           = err_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TLAST  = tlast_q;

endmodule

// File: tb/tb_axis_frame_source.sv
// Self-checking bench for axis_frame_source: directed plan steps plus random
// frames, checked against a simple buffer/frame model kept in the bench.
module tb_axis_frame_source;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic          ACLK;
  logic          ARESET;
  logic          WR_EN;
  logic [DW-1:0] WR_DATA;
  logic          START;
  logic [LW-1:0] FRAME_LEN;
  logic          BUSY;
  logic          DONE;
  logic          ERR;
  logic          M_AXIS_TVALID;
  logic [DW-1:0] M_AXIS_TDATA;
  logic          M_AXIS_TLAST;
  logic          M_AXIS_TREADY;

  int n_cmp;
  int n_bad;

  // Reference model: the buffer slots plus how many words are loaded.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_ptr;
  int            m_cnt;

  axis_frame_source #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .LEN_W      (LW)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .WR_EN         (WR_EN),
    .WR_DATA       (WR_DATA),
    .START         (START),
    .FRAME_LEN     (FRAME_LEN),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .ERR           (ERR),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [DW-1:0] d);
    WR_EN   = 1'b1;
    WR_DATA = d;
    tick();
    WR_EN   = 1'b0;
    m_mem[m_ptr] = d;
    m_ptr = (m_ptr + 1) % DEPTH;
    if (m_cnt < DEPTH) m_cnt++;
  endtask

  task automatic reject(input int len, input bit with_wr);
    START     = 1'b1;
    FRAME_LEN = LW'(len);
    WR_EN     = with_wr;
    WR_DATA   = $urandom;
    tick();
    START = 1'b0;
    WR_EN = 1'b0;
    chk("rej_err", ERR, 1);
    chk("rej_valid", M_AXIS_TVALID, 0);
    chk("rej_busy", BUSY, 0);
    tick();
    chk("rej_err_clear", ERR, 0);
    chk("rej_valid_after", M_AXIS_TVALID, 0);
  endtask

  // mode 0: ready always; mode 1: 3-cycle stall on beat 1; mode 2: random ready.
  task automatic run_frame(input int len, input int mode);
    logic [DW-1:0] exp_d[$];
    logic          exp_l[$];
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    logic [DW-1:0] x;
    logic [DW-1:0] pd;
    logic          pv, pr, pl;
    int            done_cyc, last_hs, n_done, stall, n;
    x = '0;
    for (int i = 0; i < len; i++) begin
      exp_d.push_back(m_mem[i]);
      exp_l.push_back(1'b0);
      x ^= m_mem[i];
    end
`ifdef AXIS_FRAME_SOURCE_CHECKSUM_EN
    exp_d.push_back(x);
    exp_l.push_back(1'b1);
`else
    exp_l[len-1] = 1'b1;
`endif
    START         = 1'b1;
    FRAME_LEN     = LW'(len);
    M_AXIS_TREADY = 1'b0;
    tick();
    START = 1'b0;
    chk("start_valid", M_AXIS_TVALID, 1);
    chk("start_busy", BUSY, 1);
    chk("start_err", ERR, 0);
    done_cyc = -1; last_hs = -1; n_done = 0; stall = 0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    for (int c = 0; c < 400; c++) begin
      if (DONE) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (pv && !pr) begin
        chk("stall_valid", M_AXIS_TVALID, 1);
        chk("stall_data", M_AXIS_TDATA, pd);
        chk("stall_last", M_AXIS_TLAST, pl);
      end
      if (done_cyc >= 0 && c > done_cyc) break;
      case (mode)
        0: M_AXIS_TREADY = 1'b1;
        1: begin
          M_AXIS_TREADY = !(got_d.size() == 1 && stall < 3);
          if (!M_AXIS_TREADY) stall++;
        end
        default: M_AXIS_TREADY = 1'($urandom_range(0, 1));
      endcase
      WR_EN   = 1'($urandom_range(0, 1));
      WR_DATA = $urandom;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        got_d.push_back(M_AXIS_TDATA);
        got_l.push_back(M_AXIS_TLAST);
        last_hs = c;
      end
      pv = M_AXIS_TVALID; pr = M_AXIS_TREADY; pd = M_AXIS_TDATA; pl = M_AXIS_TLAST;
      tick();
    end
    WR_EN         = 1'b0;
    M_AXIS_TREADY = 1'b0;
    chk("done_count", n_done, 1);
    chk("done_latency", done_cyc, last_hs + 1);
    chk("busy_after", BUSY, 0);
    chk("valid_after", M_AXIS_TVALID, 0);
    chk("beat_count", got_d.size(), exp_d.size());
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("beat%0d_data", i), got_d[i], exp_d[i]);
      chk($sformatf("beat%0d_last", i), got_l[i], exp_l[i]);
    end
    m_ptr = 0;
    m_cnt = 0;
  endtask

  int nw;
  int len;

  initial begin
    n_cmp = 0; n_bad = 0;
    m_ptr = 0; m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    ARESET = 1'b1; WR_EN = 1'b0; WR_DATA = '0; START = 1'b0;
    FRAME_LEN = '0; M_AXIS_TREADY = 1'b0;
    tick();
    tick();
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_valid", M_AXIS_TVALID, 0);
    chk("rst_last", M_AXIS_TLAST, 0);
    chk("rst_data", M_AXIS_TDATA, 0);
    ARESET = 1'b0;
    tick();

    // Basic two-word frame (WR_EN is toggled during the frame and must be ignored).
    wr(32'h00C80264);
    wr(32'h00000014);
    run_frame(2, 0);
    // Fill count was cleared by the frame, so any START must now be rejected.
    reject(1, 1'b0);

    // Backpressure on the second beat.
    wr(32'h00C80264);
    wr(32'h00000014);
    run_frame(2, 1);

    // Rejects; START wins over a simultaneous WR_EN.
    wr($urandom);
    wr($urandom);
    reject(0, 1'b0);
    reject(3, 1'b1);
    reject(3, 1'b0);
    run_frame(2, 2);

    // Reset on beat 2 of a 4-word frame.
    for (int i = 0; i < 4; i++) wr($urandom);
    START = 1'b1; FRAME_LEN = LW'(4); M_AXIS_TREADY = 1'b1;
    tick();
    START = 1'b0;
    chk("mid_valid", M_AXIS_TVALID, 1);
    tick();
    tick();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    M_AXIS_TREADY = 1'b0;
    chk("mid_rst_valid", M_AXIS_TVALID, 0);
    chk("mid_rst_last", M_AXIS_TLAST, 0);
    chk("mid_rst_done", DONE, 0);
    chk("mid_rst_busy", BUSY, 0);
    m_ptr = 0; m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_done", DONE, 0);
      chk("post_rst_valid", M_AXIS_TVALID, 0);
    end
    wr($urandom);
    run_frame(1, 0);

    // Wrap-around: 17 writes overwrite slot 0.
    for (int i = 1; i <= 17; i++) wr(DW'(i));
    run_frame(16, 0);

    // Random loads, lengths and ready patterns.
    for (int it = 0; it < 12; it++) begin
      nw = $urandom_range(0, 20);
      for (int k = 0; k < nw; k++) wr($urandom);
      len = $urandom_range(0, DEPTH + 1);
      if (len == 0 || len > m_cnt) reject(len, 1'($urandom_range(0, 1)));
      else run_frame(len, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_frame_source.md
Name: axis_frame_source

Overview:
- AXI-Stream master that feeds frames into the coprocessor's S_AXIS slave port.
- Control logic preloads a small word buffer through a simple write port, then pulses START.
- The block streams FRAME_LEN words with full TVALID/TREADY handshaking and asserts TLAST on the final beat.
- Replaces hand-driven stimulus on the slave side and serves as the reusable transmit end of the stream interface.

Parameters:
- DATA_WIDTH, 32, width of TDATA and WR_DATA.
- DEPTH, 16, buffer capacity in words; must be a power of two and at least 2.
- LEN_W, $clog2(DEPTH)+1, width of FRAME_LEN and of the internal fill count.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  synchronous active-high reset.
- WR_EN  in  1  buffer write strobe.
- WR_DATA  in  DATA_WIDTH  word to append to the buffer.
- START  in  1  one-cycle request to transmit a frame.
- FRAME_LEN  in  LEN_W  number of payload words, sampled on START.
- BUSY  out  1  high from START acceptance until DONE.
- DONE  out  1  one-cycle pulse after the last beat is accepted.
- ERR  out  1  one-cycle pulse when a START is rejected.
- M_AXIS_TVALID  out  1  stream valid.
- M_AXIS_TDATA  out  DATA_WIDTH  stream data, registered.
- M_AXIS_TLAST  out  1  high on the final beat of the frame.
- M_AXIS_TREADY  in  1  downstream ready.

Behaviour:
- Interface:
  - One clock, ACLK.
  - Reset ARESET is synchronous and active-high.
- Reset:
  - BUSY, DONE, ERR, M_AXIS_TVALID, M_AXIS_TLAST and M_AXIS_TDATA all go to 0.
  - Write pointer, fill count and read index go to 0; state goes to IDLE.
  - Buffer RAM contents are not cleared.
- Reset mid-frame:
  - TVALID drops at that same edge and the frame is abandoned.
  - No TLAST or DONE is issued for it.
- Writes:
  - Accepted only in IDLE.
  - Each write stores WR_DATA at the write pointer, increments the pointer modulo DEPTH, and increments the fill count, saturating at DEPTH.
  - A write issued when the count is already DEPTH overwrites the oldest slot by wrap-around.
  - WR_EN outside IDLE is ignored.
- START in IDLE:
  - Rejected when FRAME_LEN == 0 or FRAME_LEN > fill count: ERR pulses for 1 cycle and the block stays in IDLE.
  - WR_EN in the same cycle as START is ignored; START has priority.
  - START outside IDLE is ignored and produces no ERR.
- States:
  - IDLE: on a valid START, latch the length, load buffer[0] into TDATA, set TVALID=1 and BUSY=1, and set TLAST=(len==1). Go to SEND.
  - SEND, on TVALID and TREADY:
    - If this is not the last beat, load the next word at the next edge; TVALID stays 1, giving zero-bubble streaming.
    - If it is the last beat, go to CSUM when the feature is enabled, otherwise to FIN.
  - CSUM: present the checksum word (see Optional Feature).
  - FIN: TVALID=0, DONE=1 for one cycle, BUSY=0, write pointer and fill count reset to 0. Go to IDLE.
- Handshake rules:
  - TDATA and TLAST are held stable while TVALID is high and TREADY is low.
  - TVALID never drops before the handshake completes.
  - TVALID does not depend combinationally on TREADY.
- Latency:
  - START at edge n gives TVALID=1 after edge n.
  - With TREADY held high, a frame of L words takes L cycles, followed by DONE one cycle after the last beat.
- Reads: always start at index 0. The buffer is read in written order and data is not consumed beyond the latched length.

Optional Feature:
- Macro: AXIS_FRAME_SOURCE_CHECKSUM_EN.
- Defined:
  - A running XOR of all payload words is kept.
  - After the last payload beat, one extra beat is sent carrying that XOR word, and it carries TLAST.
  - Payload beats then have TLAST=0, and the frame is L+1 beats.
- Undefined: the CSUM state and the XOR register are absent, and TLAST is on payload word L.

Decomposition:
- Package axis_frame_source_pkg holds:
  - the state enum (IDLE, SEND, CSUM, FIN);
  - DATA_WIDTH_DEFAULT and DEPTH_DEFAULT;
  - the LEN_W computation function.
- Sub-module axis_frame_buffer: a DEPTH x DATA_WIDTH RAM with a synchronous write port and an asynchronous read port, plus the write pointer and fill count.
- The top level keeps the FSM, the output register and the checksum logic.

Test Plan:
- Basic frame: write 0x00C80264 then 0x00000014, START with FRAME_LEN=2 and TREADY=1.
  - Required: 2 consecutive beats, TLAST on 0x00000014, DONE 1 cycle later, BUSY low afterwards.
- Backpressure: same frame with TREADY low for 3 cycles mid-frame.
  - Required: 0x00000014 held stable with TVALID=1 throughout the stall.
  - Each word is transferred exactly once.
- Rejects:
  - START with FRAME_LEN=0 → ERR pulse, no TVALID.
  - START with FRAME_LEN=3 after only 2 writes → ERR pulse, no TVALID.
  - WR_EN during SEND → ignored, and the next frame starts with fill count 0.
- Reset mid-frame: assert ARESET on beat 2 of a 4-word frame.
  - Required: TVALID=0 next cycle, no DONE, no TLAST.
  - A following load of 1 word plus START with FRAME_LEN=1 sends a single beat with TLAST set.
- Wrap-around: 17 writes with values 1..17 at DEPTH=16, then START with FRAME_LEN=16.
  - Required: 16 beats, first beat 17 (slot 0 overwritten), then 2..16.
- Checksum, with AXIS_FRAME_SOURCE_CHECKSUM_EN defined: basic frame.
  - Required: 3 beats, the third being 0x00C80270 with TLAST; payload beats have TLAST=0.
